// File: rtl/mcu_frame_receiver.sv
// Receiver for the 3-wire open-drain MCU command link: decodes 72-bit EN/CLOCK/DATA frames
// into a command byte plus 64-bit payload and tracks the PTT flag and last IP address.
module mcu_frame_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 16384
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mcu_en_in,
  input  logic        mcu_clock_in,
  input  logic        mcu_data_in,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [63:0] frame_payload,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic        busy,
  output logic        ptt,
  output logic [31:0] ip_addr,
  output logic        ip_valid,
  output logic        ip_update
);

  localparam int unsigned         TimerW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TimerW-1:0]   TimeoutVal = TimerW'(TIMEOUT_CYC);
  localparam logic [6:0]          FrameBits  = 7'd72;

  typedef enum logic [1:0] {StIdle, StShift, StDeliver, StWaitRel} state_e;

  logic [SYNC_STAGES-1:0] r_en_sync, r_clk_sync, r_dat_sync;
  logic                   r_en_d, r_clk_d;
  logic [SYNC_STAGES:0]   r_warm;

  logic w_en_s, w_clk_s, w_dat_s, w_primed;
  logic w_en_fall, w_en_rise, w_clk_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_en_sync  <= '1;
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_en_d     <= 1'b1;
      r_clk_d    <= 1'b1;
      r_warm     <= '0;
    end else begin
      r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], mcu_en_in};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], mcu_clock_in};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], mcu_data_in};
      r_en_d     <= w_en_s;
      r_clk_d    <= w_clk_s;
      r_warm     <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_en_s  = r_en_sync[SYNC_STAGES-1];
  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // The preset-high chain makes a pin already low at reset look like a falling edge;
  // edges are only trusted once real pin samples have filled the chain and the delay flop.
  assign w_primed   = r_warm[SYNC_STAGES];
  assign w_en_fall  = w_primed & r_en_d & ~w_en_s;
  assign w_en_rise  = ~r_en_d & w_en_s;
  assign w_clk_rise = ~r_clk_d & w_clk_s;

  state_e             r_state, w_state_d;
  logic [71:0]        r_shift, w_shift_d;
  logic [6:0]         r_cnt, w_cnt_d;
  logic [TimerW-1:0]  r_timer, w_timer_d;
  logic               r_valid, w_valid_d;
  logic               r_error, w_error_d;
  logic [1:0]         r_code, w_code_d;
  logic [7:0]         r_cmd, w_cmd_d;
  logic [63:0]        r_payload, w_payload_d;
  logic               r_ptt, w_ptt_d;
  logic [31:0]        r_ip, w_ip_d;
  logic               r_ipv, w_ipv_d;
  logic               r_ipu, w_ipu_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= '0;
      r_cmd     <= '0;
      r_payload <= '0;
      r_ptt     <= 1'b0;
      r_ip      <= '0;
      r_ipv     <= 1'b0;
      r_ipu     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_cnt     <= w_cnt_d;
      r_timer   <= w_timer_d;
      r_valid   <= w_valid_d;
      r_error   <= w_error_d;
      r_code    <= w_code_d;
      r_cmd     <= w_cmd_d;
      r_payload <= w_payload_d;
      r_ptt     <= w_ptt_d;
      r_ip      <= w_ip_d;
      r_ipv     <= w_ipv_d;
      r_ipu     <= w_ipu_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_cnt_d     = r_cnt;
    w_timer_d   = r_timer;
    w_valid_d   = 1'b0;
    w_error_d   = 1'b0;
    w_code_d    = r_code;
    w_cmd_d     = r_cmd;
    w_payload_d = r_payload;
    w_ptt_d     = r_ptt;
    w_ip_d      = r_ip;
    w_ipv_d     = r_ipv;
    w_ipu_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_en_fall) begin
          w_state_d = StShift;
          w_cnt_d   = '0;
          w_timer_d = '0;
        end else if (w_primed && !w_en_s) begin
          w_state_d = StWaitRel;
        end
      end
      StShift: begin
        if (w_clk_rise && r_cnt == FrameBits) begin
          w_error_d = 1'b1;
          w_code_d  = 2'd2;
          w_state_d = StWaitRel;
        end else begin
          if (w_clk_rise) begin
            w_shift_d = {r_shift[70:0], w_dat_s};
            w_cnt_d   = r_cnt + 7'd1;
            w_timer_d = '0;
          end else if (r_timer != TimeoutVal) begin
            w_timer_d = r_timer + 1'b1;
          end
          // A bit arriving with the EN release is already counted in w_cnt_d.
          if (w_en_rise) begin
            if (w_cnt_d == FrameBits) begin
              w_state_d   = StDeliver;
              w_valid_d   = 1'b1;
              w_cmd_d     = w_shift_d[71:64];
              w_payload_d = w_shift_d[63:0];
              case (w_shift_d[71:64])
                8'd3: begin
                  w_ip_d  = w_shift_d[63:32];
                  w_ipv_d = 1'b1;
                  w_ipu_d = 1'b1;
                end
                8'd5:    w_ptt_d = 1'b1;
                8'd6:    w_ptt_d = 1'b0;
                default: ;
              endcase
            end else begin
              w_error_d = 1'b1;
              w_code_d  = 2'd1;
              w_state_d = StIdle;
            end
          end else if (!w_clk_rise && r_timer == TimeoutVal) begin
            w_error_d = 1'b1;
            w_code_d  = 2'd3;
            w_state_d = StWaitRel;
          end
        end
      end
      StDeliver: w_state_d = StIdle;
      StWaitRel: begin
        if (w_en_s) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign frame_valid   = r_valid;
  assign frame_cmd     = r_cmd;
  assign frame_payload = r_payload;
  assign frame_error   = r_error;
  assign error_code    = r_code;
  assign busy          = (r_state == StShift) || (r_state == StWaitRel);
  assign ptt           = r_ptt;
  assign ip_addr       = r_ip;
  assign ip_valid      = r_ipv;
  assign ip_update     = r_ipu;

endmodule

// File: tb/tb_mcu_frame_receiver.sv
// Bench for mcu_frame_receiver: directed frame table, hand-written corner sequences and
// random frames scored against a frame-level model of the decoded state.
module tb_mcu_frame_receiver;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned TimeoutCyc = 16384;
  // Pin change at a negedge is seen at the synchronizer output after SyncStages edges,
  // and frame_valid registers one edge later.
  localparam int ExpLat = SyncStages + 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mcu_en = 1'b1;
  logic        mcu_clk = 1'b1;
  logic        mcu_dat = 1'b1;
  logic        frame_valid, frame_error, busy, ptt, ip_valid, ip_update;
  logic [7:0]  frame_cmd;
  logic [63:0] frame_payload;
  logic [1:0]  error_code;
  logic [31:0] ip_addr;

  always #5 clock = ~clock;

  mcu_frame_receiver #(
    .SYNC_STAGES(SyncStages),
    .TIMEOUT_CYC(TimeoutCyc)
  ) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mcu_en_in    (mcu_en),
    .mcu_clock_in (mcu_clk),
    .mcu_data_in  (mcu_dat),
    .frame_valid  (frame_valid),
    .frame_cmd    (frame_cmd),
    .frame_payload(frame_payload),
    .frame_error  (frame_error),
    .error_code   (error_code),
    .busy         (busy),
    .ptt          (ptt),
    .ip_addr      (ip_addr),
    .ip_valid     (ip_valid),
    .ip_update    (ip_update)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_error = 0;
  int n_ipu = 0;

  always @(negedge clock) begin
    if (frame_valid) n_valid <= n_valid + 1;
    if (frame_error) n_error <= n_error + 1;
    if (ip_update)   n_ipu   <= n_ipu + 1;
  end

  // Frame-level model of the decoded state
  logic [7:0]  m_cmd = '0;
  logic [63:0] m_payload = '0;
  logic        m_ptt = 1'b0;
  logic [31:0] m_ip = '0;
  logic        m_ipv = 1'b0;
  logic [1:0]  m_code = '0;

  task automatic model_frame(input logic [7:0] cmd, input logic [63:0] pl, input int nbits);
    if (nbits == 72) begin
      m_cmd     = cmd;
      m_payload = pl;
      if (cmd == 8'd3) begin
        m_ip  = pl[63:32];
        m_ipv = 1'b1;
      end
      if (cmd == 8'd5) m_ptt = 1'b1;
      if (cmd == 8'd6) m_ptt = 1'b0;
    end else if (nbits > 72) begin
      m_code = 2'd2;
    end else begin
      m_code = 2'd1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cmd"}, 64'(frame_cmd), 64'(m_cmd));
    check({tag, ".payload"}, frame_payload, m_payload);
    check({tag, ".ptt"}, 64'(ptt), 64'(m_ptt));
    check({tag, ".ip"}, 64'(ip_addr), 64'(m_ip));
    check({tag, ".ipv"}, 64'(ip_valid), 64'(m_ipv));
    check({tag, ".code"}, 64'(error_code), 64'(m_code));
  endtask

  task automatic send_cell(input logic d);
    mcu_dat = d;
    mcu_clk = 1'b0;
    repeat (3) @(negedge clock);
    mcu_clk = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [63:0] pl, input int nbits,
                           output int dv, output int de, output int dip, output int early,
                           output int lat, output logic bpre);
    logic [71:0] bits;
    int v0, e0, i0;
    bits = {cmd, pl};
    v0 = n_valid;
    e0 = n_error;
    i0 = n_ipu;
    mcu_en = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < nbits; i++) send_cell((i < 72) ? bits[71-i] : 1'b0);
    repeat (2) @(negedge clock);
    early = n_error - e0;
    bpre = busy;
    mcu_en = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (frame_valid && lat < 0) lat = k;
    end
    repeat (4) @(negedge clock);
    dv  = n_valid - v0;
    de  = n_error - e0;
    dip = n_ipu - i0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [63:0] pl;
    int          nbits;
    int          exp_valid;
    int          exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_cmd;
    logic        exp_ptt;
    logic [31:0] exp_ip;
    logic        exp_ipv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int dv, de, dip, early, lat, v0, e0, i0, r, nb;
    logic bpre;
    logic [7:0] cmd;
    logic [63:0] pl;

    tbl[0] = '{8'h03, 64'hC0A8010A_00000000, 72, 1, 0, 2'd0, 8'h03, 1'b0, 32'hC0A8010A, 1'b1};
    tbl[1] = '{8'h05, 64'h0, 72, 1, 0, 2'd0, 8'h05, 1'b1, 32'hC0A8010A, 1'b1};
    tbl[2] = '{8'h06, 64'h01234567_89ABCDEF, 72, 1, 0, 2'd0, 8'h06, 1'b0, 32'hC0A8010A, 1'b1};
    tbl[3] = '{8'h07, 64'hFFFFFFFF_FFFFFFFF, 40, 0, 1, 2'd1, 8'h06, 1'b0, 32'hC0A8010A, 1'b1};
    tbl[4] = '{8'h04, 64'h11223344_55667788, 72, 1, 0, 2'd1, 8'h04, 1'b0, 32'hC0A8010A, 1'b1};
    tbl[5] = '{8'h03, 64'hDEADBEEF_CAFEF00D, 73, 0, 1, 2'd2, 8'h04, 1'b0, 32'hC0A8010A, 1'b1};
    tbl[6] = '{8'h03, 64'h0A000001_AABBCCDD, 72, 1, 0, 2'd2, 8'h03, 1'b0, 32'h0A000001, 1'b1};
    tbl[7] = '{8'h05, 64'h0, 0, 0, 1, 2'd1, 8'h03, 1'b0, 32'h0A000001, 1'b1};

    repeat (3) @(negedge clock);
    check("rst.valid", 64'(frame_valid), 64'd0);
    check("rst.error", 64'(frame_error), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ipu", 64'(ip_update), 64'd0);
    check_model("rst");
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("idle.busy", 64'(busy), 64'd0);

    for (int t = 0; t < 8; t++) begin
      run_frame(tbl[t].cmd, tbl[t].pl, tbl[t].nbits, dv, de, dip, early, lat, bpre);
      model_frame(tbl[t].cmd, tbl[t].pl, tbl[t].nbits);
      check($sformatf("tbl%0d.valid_cnt", t), 64'(dv), 64'(tbl[t].exp_valid));
      check($sformatf("tbl%0d.err_cnt", t), 64'(de), 64'(tbl[t].exp_err));
      check($sformatf("tbl%0d.ipu_cnt", t), 64'(dip),
            64'((tbl[t].exp_valid == 1 && tbl[t].cmd == 8'h03) ? 1 : 0));
      check($sformatf("tbl%0d.early_err", t), 64'(early), 64'((tbl[t].nbits > 72) ? 1 : 0));
      check($sformatf("tbl%0d.busy_pre", t), 64'(bpre), 64'd1);
      check($sformatf("tbl%0d.busy_post", t), 64'(busy), 64'd0);
      check($sformatf("tbl%0d.code", t), 64'(error_code), 64'(tbl[t].exp_code));
      check($sformatf("tbl%0d.cmd", t), 64'(frame_cmd), 64'(tbl[t].exp_cmd));
      check($sformatf("tbl%0d.ptt", t), 64'(ptt), 64'(tbl[t].exp_ptt));
      check($sformatf("tbl%0d.ip", t), 64'(ip_addr), 64'(tbl[t].exp_ip));
      check($sformatf("tbl%0d.ipv", t), 64'(ip_valid), 64'(tbl[t].exp_ipv));
      check($sformatf("tbl%0d.payload", t), frame_payload, m_payload);
      if (tbl[t].exp_valid == 1) check($sformatf("tbl%0d.latency", t), 64'(lat), 64'(ExpLat));
    end

    // Timeout: 10 bits, then silence with EN held low
    v0 = n_valid;
    e0 = n_error;
    mcu_en = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 10; i++) send_cell(i[0]);
    repeat (TimeoutCyc - 20) @(negedge clock);
    check("to.not_early", 64'(n_error - e0), 64'd0);
    repeat (25) @(negedge clock);
    check("to.err_cnt", 64'(n_error - e0), 64'd1);
    check("to.code", 64'(error_code), 64'd3);
    check("to.busy_held", 64'(busy), 64'd1);
    mcu_en = 1'b1;
    repeat (10) @(negedge clock);
    m_code = 2'd3;
    check("to.busy_post", 64'(busy), 64'd0);
    check("to.err_final", 64'(n_error - e0), 64'd1);
    check("to.valid_cnt", 64'(n_valid - v0), 64'd0);
    check_model("to");

    // Reset in the middle of a frame with EN still low
    mcu_en = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 30; i++) send_cell(1'b1);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    m_cmd = '0; m_payload = '0; m_ptt = 1'b0; m_ip = '0; m_ipv = 1'b0; m_code = '0;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.valid", 64'(frame_valid), 64'd0);
    check_model("mrst");
    reset_n = 1'b1;
    v0 = n_valid;
    e0 = n_error;
    i0 = n_ipu;
    repeat (10) @(negedge clock);
    check("mrst.wait_rel_busy", 64'(busy), 64'd1);
    mcu_en = 1'b1;
    repeat (10) @(negedge clock);
    check("mrst.busy_post", 64'(busy), 64'd0);
    check("mrst.pulses", 64'((n_valid - v0) + (n_error - e0) + (n_ipu - i0)), 64'd0);
    check_model("mrst.post");
    run_frame(8'h05, 64'h0, 72, dv, de, dip, early, lat, bpre);
    model_frame(8'h05, 64'h0, 72);
    check("mrst.cmd5_valid", 64'(dv), 64'd1);
    check("mrst.cmd5_err", 64'(de), 64'd0);
    check_model("mrst.cmd5");

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      nb = (r < 7) ? 72 : (r == 7) ? int'($urandom_range(1, 71)) : int'($urandom_range(73, 75));
      r = $urandom_range(0, 7);
      cmd = (r == 7) ? 8'($urandom) : 8'(r);
      pl = {32'($urandom), 32'($urandom)};
      run_frame(cmd, pl, nb, dv, de, dip, early, lat, bpre);
      model_frame(cmd, pl, nb);
      check($sformatf("rnd%0d.valid_cnt", n), 64'(dv), 64'((nb == 72) ? 1 : 0));
      check($sformatf("rnd%0d.err_cnt", n), 64'(de), 64'((nb != 72) ? 1 : 0));
      check($sformatf("rnd%0d.ipu_cnt", n), 64'(dip), 64'((nb == 72 && cmd == 8'd3) ? 1 : 0));
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_frame_receiver.md
Name: mcu_frame_receiver

Overview:
- Receiving end of the 3-wire open-drain MCU command link (EN / CLOCK / DATA). The FPGA-side controller drives this link to send 9-byte command frames to the front-panel MCU.
- This block decodes those frames in a companion CPLD/FPGA or a loop-back test build.
- It delivers each complete frame as a command byte plus a 64-bit payload.
- It maintains decoded state: PTT flag and last IP address.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).
- TIMEOUT_CYC, 16384, clock cycles allowed between CLOCK rising edges while EN is low before the frame is aborted.

Ports:
- clock  input  1  system clock; must be at least 4x the link bit-cell rate (one bit cell = 3 sender clocks).
- reset_n  input  1  asynchronous active-low reset.
- mcu_en_in  input  1  EN line as resolved at the pin (pulled up; 0 = frame active).
- mcu_clock_in  input  1  CLOCK line as resolved at the pin (idle 1).
- mcu_data_in  input  1  DATA line as resolved at the pin (idle 1).
- frame_valid  output  1  one-cycle pulse when a good frame is delivered.
- frame_cmd  output  8  byte 0 of the last good frame.
- frame_payload  output  64  bytes 1..8 of the last good frame; byte 1 in [63:56].
- frame_error  output  1  one-cycle pulse when a frame is aborted.
- error_code  output  2  1 = short, 2 = overrun, 3 = timeout; holds until the next error.
- busy  output  1  high while in SHIFT or WAIT_REL.
- ptt  output  1  PTT state: set by cmd 5, cleared by cmd 6.
- ip_addr  output  32  payload bytes 1..4 of the last cmd-3 frame; byte 1 in [31:24].
- ip_valid  output  1  sticky; set by the first cmd-3 frame.
- ip_update  output  1  one-cycle pulse on each cmd-3 frame.

Behaviour:
- Reset (async, reset_n = 0):
  - All outputs 0; error_code 0; ip_addr 0.
  - Synchronizer flops preset to 1 (released line).
  - State IDLE.
- Inputs: each pin passes through SYNC_STAGES flops. Edge detect compares the synced value with a one-cycle-delayed copy. Only synced signals are used.
- Frame format:
  - 72 bits, MSB first, byte 0 first.
  - DATA is sampled on the synced CLOCK rising edge.
  - A frame is delimited by EN low ... EN high.
- States: IDLE, SHIFT, DELIVER, WAIT_REL.
- IDLE:
  - On an EN falling edge: go to SHIFT; bit_cnt = 0; timer = 0.
  - If EN is already low without a falling edge (e.g. after reset), go to WAIT_REL.
  - CLOCK/DATA activity while EN is high is ignored.
- SHIFT:
  - Each CLOCK rising edge: shift_reg = {shift_reg[70:0], data_s}; bit_cnt++ (7-bit counter); timer = 0.
  - If a rising edge arrives when bit_cnt is already 72: frame_error pulse, error_code = 2, go to WAIT_REL.
  - Otherwise timer++ each cycle. When timer reaches TIMEOUT_CYC: frame_error, error_code = 3, go to WAIT_REL.
  - On an EN rising edge: bit_cnt == 72 goes to DELIVER. Any other count (including 0) gives frame_error, error_code = 1, and returns to IDLE.
  - If a CLOCK rising edge and an EN rising edge fall in the same cycle, the bit is counted first. The EN check then uses the updated count.
- DELIVER (1 cycle), then IDLE:
  - frame_cmd = shift_reg[71:64]; frame_payload = shift_reg[63:0].
  - frame_valid pulses in the same cycle as the register update. Latency from EN rising edge (synced) to frame_valid = 1 cycle.
  - Command decode, applied in the same cycle:
    - cmd 3: ip_addr = shift_reg[63:32]; ip_valid = 1; ip_update pulse.
    - cmd 5: ptt = 1.
    - cmd 6: ptt = 0.
    - cmd 1, 2, 4 and all other values: no side effect; frame_valid is still asserted.
  - Stale payload bytes (e.g. cmd 4 carries only 3 meaningful bytes) are delivered unchanged. Filtering them is not this block's job.
- WAIT_REL:
  - Ignore CLOCK/DATA until synced EN is high, then go to IDLE.
  - No further error pulses are produced for the same frame.
- Outputs frame_cmd, frame_payload, ip_addr and ptt hold until overwritten. Error frames never modify them.
- Timer width: ceil(log2(TIMEOUT_CYC + 1)) bits. It saturates and never wraps.
- Reset mid-frame: the partial frame is discarded with no pulses. After release, a still-low EN leads to WAIT_REL.

Test Plan:
- Send cmd 3 with IP 192.168.1.10 (bytes 03 C0 A8 01 0A 00 00 00 00) -> one frame_valid, frame_cmd = 0x03, ip_addr = 0xC0A8010A, ip_valid = 1, ip_update pulses once, ptt = 0.
- Send cmd 5, then cmd 6, with 1 ms idle between -> ptt rises 1 cycle after the first EN release and falls after the second; two frame_valid pulses, no errors.
- Send 40 bits, then release EN -> frame_error, error_code = 1, busy falls; frame_cmd and ip_addr unchanged. A following good cmd-4 frame gives frame_cmd = 0x04.
- Send 73 CLOCK pulses within one EN-low window -> frame_error on the 73rd edge, error_code = 2. No frame_valid at the EN release; next frame accepted normally.
- Hold EN low, send 10 bits, then stop for TIMEOUT_CYC + 5 cycles -> frame_error, error_code = 3, busy stays high until EN is released, then IDLE.
- Assert reset_n = 0 after 30 bits while EN stays low; release, then EN goes high -> no pulses, all outputs 0; the next full cmd-5 frame sets ptt = 1.
